// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and helpers for the data memory controller.
package dmem_pkg;

    // Access size encoding as carried on req_size (value 3 is never legal)
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Controller states: waiting for a request, counting latency, holding a response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Latency counter width, enough for LATENCY up to 15
    localparam int LAT_W = 4;

    // Low address bits that must be zero for an access of the given size
    function automatic logic [1:0] sizeMask(input logic [1:0] size);
        case (size)
            SZ_HALF: sizeMask = 2'b01;
            SZ_WORD: sizeMask = 2'b11;
            default: sizeMask = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH x 8 byte storage with a DW-wide big-endian window.
// Lane k of the window (bits DW-1-8k downto DW-8-8k) maps to byte base+k,
// so lane 0 is the most significant byte. Addresses wrap modulo DEPTH.
// Contents are not cleared by reset and are undefined until written.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int NB    = DW / 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] base_i,
    input  logic [NB-1:0]    strb_i,
    input  logic [DW-1:0]    wdata_i,
    output logic [DW-1:0]    rdata_o
);

    logic [7:0] mem [DEPTH];

    // Asynchronous read of NB consecutive bytes starting at the base address
    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NB; k++) begin
            rdata_o[DW-1-8*k -: 8] = mem[base_i + IDX_W'(k)];
        end
    end

    // Byte-strobed write of the window lanes into consecutive bytes
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (we_i && strb_i[k]) begin
                mem[base_i + IDX_W'(k)] <= wdata_i[DW-1-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: parametrised byte-addressed data memory with valid/ready
// request and response channels, big-endian byte/half/word accesses and a
// configurable access latency.
// Optional feature macro: DMEM_ERR_RESP_EN
//   defined   -> misaligned or out-of-range accesses are rejected with rsp_err
//   undefined -> address is aligned down to the access size and wrapped modulo DEPTH
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DEPTH   = 256,
    parameter int AW      = 16,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DW / 8;

    state_e           state_q, state_d;
    logic [LAT_W-1:0] count_q, count_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             rspValid_q, rspValid_d;
    logic [DW-1:0]    rspRdata_q, rspRdata_d;
    logic             rspErr_q, rspErr_d;

    logic             sizeIllegal;
    logic             accessErr;
    logic [AW-1:0]    alignMask;
    logic [IDX_W-1:0] memBase;
    logic             memWe;
    logic [NB-1:0]    memStrb;
    logic [DW-1:0]    memWdata;
    logic [DW-1:0]    memRdata;
    logic [DW-1:0]    loadData;
    logic             lastBusyCycle;

`ifdef DMEM_ERR_RESP_EN
    logic             misaligned;
    logic             outOfRange;
`else
    logic [AW-1:0]    addrAligned;
`endif

    // Decode legality, alignment and the storage base address of the held request
    always_comb begin
        sizeIllegal = (size_q == 2'd3) || ((size_q == SZ_WORD) && (DW == 16));
        alignMask   = AW'(sizeMask(size_q));
`ifdef DMEM_ERR_RESP_EN
        misaligned  = (addr_q & alignMask) != '0;
        outOfRange  = {1'b0, addr_q} >= (AW+1)'(DEPTH);
        accessErr   = sizeIllegal || misaligned || outOfRange;
        memBase     = addr_q[IDX_W-1:0];
`else
        addrAligned = addr_q & ~alignMask;
        accessErr   = sizeIllegal;
        memBase     = addrAligned[IDX_W-1:0];
`endif
    end

    // Steer store data into the leading window lanes and build byte strobes
    always_comb begin
        memWdata = '0;
        memStrb  = '0;
        case (size_q)
            SZ_BYTE: begin
                memWdata[DW-1 -: 8]  = wdata_q[7:0];
                memStrb              = NB'(1);
            end
            SZ_HALF: begin
                memWdata[DW-1 -: 16] = wdata_q[15:0];
                memStrb              = NB'(3);
            end
            SZ_WORD: begin
                memWdata             = wdata_q;
                memStrb              = '1;
            end
            default: begin
                memWdata             = '0;
                memStrb              = '0;
            end
        endcase
    end

    // Extract load data from the leading window lanes, right-aligned and zero-extended
    always_comb begin
        loadData = '0;
        case (size_q)
            SZ_BYTE: loadData = DW'(memRdata[DW-1 -: 8]);
            SZ_HALF: loadData = DW'(memRdata[DW-1 -: 16]);
            SZ_WORD: loadData = memRdata;
            default: loadData = '0;
        endcase
    end

    // The store commits on the same edge that raises rsp_valid; reset on that edge blocks it
    assign lastBusyCycle = (state_q == BUSY) && (count_q == '0);
    assign memWe         = lastBusyCycle && we_q && !accessErr && !rst;

    dmem_byte_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (memWe),
        .base_i  (memBase),
        .strb_i  (memStrb),
        .wdata_i (memWdata),
        .rdata_o (memRdata)
    );

    // State register and request/response holding registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    // Next-state logic: accept, count down the latency, then hold the response until taken
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rspValid_d = rspValid_q;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    count_d = LAT_W'(LATENCY - 1);
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    state_d    = RESP;
                    rspValid_d = 1'b1;
                    rspErr_d   = accessErr;
                    rspRdata_d = (we_q || accessErr) ? '0 : loadData;
                end else begin
                    count_d = count_q - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d    = IDLE;
                    rspValid_d = 1'b0;
                    rspRdata_d = '0;
                    rspErr_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl (DW=32, DEPTH=256, LATENCY=3).
// Expected data comes from a plain byte-array model of the memory's access rules.
// Honours DMEM_ERR_RESP_EN the same way the design does.
module tb_dmem_ctrl;

    localparam int DW      = 32;
    localparam int DEPTH   = 256;
    localparam int AW      = 16;
    localparam int LATENCY = 3;
    localparam int TIMEOUT = 50;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    logic [7:0] refMem [DEPTH];

    dmem_ctrl #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to timestamp request acceptance
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference model: perform one access on refMem following the memory's rules
    function automatic void modelAccess(input logic we, input logic [1:0] size, input int addr,
                                        input logic [31:0] wdata,
                                        output logic [31:0] expData, output logic expErr);
        int n;
        int a;
        expData = 0;
        expErr  = 1'b0;
        n = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2 && DW == 32) ? 4 : 0;
        if (n == 0) begin
            expErr = 1'b1;
            return;
        end
`ifdef DMEM_ERR_RESP_EN
        if ((addr % n) != 0 || addr >= DEPTH) begin
            expErr = 1'b1;
            return;
        end
        a = addr;
`else
        a = ((addr / n) * n) % DEPTH;
`endif
        for (int i = 0; i < n; i++) begin
            if (we) refMem[a + i] = 8'((wdata >> (8 * (n - 1 - i))) & 32'hFF);
            else    expData = (expData << 8) | 32'(refMem[a + i]);
        end
    endfunction

    // Drive one request, wait for its response and take it; reports accept time and latency
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata,
                                 output logic [DW-1:0] rdata, output logic err,
                                 output int latency, output int acceptCycle);
        int waitCount;
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        waitCount = 0;
        while (req_ready !== 1'b1 && waitCount < TIMEOUT) begin
            @(posedge clk); #1;
            waitCount++;
        end
        @(posedge clk); #1;
        acceptCycle = cycleCount;
        req_valid   = 1'b0;
        latency     = 0;
        while (rsp_valid !== 1'b1 && latency < TIMEOUT) begin
            @(posedge clk); #1;
            latency++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL response_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, latency);
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Reset held for two cycles leaves the controller idle with a cleared response
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== '0)   begin errors++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0)   begin errors++; $display("[TB] FAIL reset_rsp_err: got %b want 0", rsp_err); end
    endtask

    // Give every byte a known random value through byte stores
    task automatic test_fill();
        logic [DW-1:0] rdata, expData;
        logic err, expErr;
        int lat, acc;
        for (int a = 0; a < DEPTH; a++) begin
            logic [31:0] v;
            v = $urandom & 32'hFF;
            modelAccess(1'b1, 2'd0, a, v, expData, expErr);
            applyStimulus(1'b1, 2'd0, AW'(a), v, rdata, err, lat, acc);
            checks++;
            if (rdata !== '0 || err !== 1'b0) begin
                errors++;
                $display("[TB] FAIL fill_store @%0h: rdata=%h err=%b want rdata=0 err=0", a, rdata, err);
            end
        end
    endtask

    // Known word stored then read back as word, byte, half and misaligned half
    task automatic test_big_endian();
        logic [DW-1:0] rdata, expData;
        logic err, expErr;
        int lat, acc;
        modelAccess(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, expData, expErr);
        applyStimulus(1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, rdata, err, lat, acc);
        checks++; if (lat != LATENCY) begin errors++; $display("[TB] FAIL store_latency: got %0d want %0d", lat, LATENCY); end
        checks++; if (rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("[TB] FAIL store_rsp: rdata=%h err=%b want 0/0", rdata, err); end
        applyStimulus(1'b0, 2'd2, 16'h0010, '0, rdata, err, lat, acc);
        checks++; if (lat != LATENCY) begin errors++; $display("[TB] FAIL load_latency: got %0d want %0d", lat, LATENCY); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL load_word: got %h want deadbeef", rdata); end
        applyStimulus(1'b0, 2'd0, 16'h0010, '0, rdata, err, lat, acc);
        checks++; if (rdata !== 32'h000000DE) begin errors++; $display("[TB] FAIL load_byte: got %h want 000000de", rdata); end
        applyStimulus(1'b0, 2'd1, 16'h0012, '0, rdata, err, lat, acc);
        checks++; if (rdata !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL load_half: got %h want 0000beef", rdata); end
        applyStimulus(1'b0, 2'd1, 16'h0011, '0, rdata, err, lat, acc);
`ifdef DMEM_ERR_RESP_EN
        checks++; if (rdata !== 32'h0 || err !== 1'b1) begin errors++; $display("[TB] FAIL misaligned_half: rdata=%h err=%b want 0/1", rdata, err); end
`else
        checks++; if (rdata !== 32'h0000DEAD || err !== 1'b0) begin errors++; $display("[TB] FAIL misaligned_half: rdata=%h err=%b want 0000dead/0", rdata, err); end
`endif
        applyStimulus(1'b0, 2'd3, 16'h0010, '0, rdata, err, lat, acc);
        checks++; if (rdata !== 32'h0 || err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_size: rdata=%h err=%b want 0/1", rdata, err); end
    endtask

    // Response held stable while the consumer stalls; next request accepted right after handshake
    task automatic test_hold();
        logic [31:0] expData, expByte;
        logic expErr;
        int waitCount;
        modelAccess(1'b0, 2'd2, 32'h10, 0, expData, expErr);
        modelAccess(1'b0, 2'd0, 32'h10, 0, expByte, expErr);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 16'h0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitCount = 0;
        while (rsp_valid !== 1'b1 && waitCount < TIMEOUT) begin @(posedge clk); #1; waitCount++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== expData || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_stable cycle %0d: valid=%b rdata=%h err=%b ready=%b want 1/%h/0/0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, expData);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        req_valid = 1'b1; req_size = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL next_accept: ready=%b want 0", req_ready); end
        waitCount = 0;
        while (rsp_valid !== 1'b1 && waitCount < TIMEOUT) begin @(posedge clk); #1; waitCount++; end
        checks++; if (rsp_rdata !== expByte) begin errors++; $display("[TB] FAIL next_data: got %h want %h", rsp_rdata, expByte); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // Reset while a store is in flight drops it; reset while a response waits discards it
    task automatic test_reset_midflight();
        logic [DW-1:0] rdata;
        logic [31:0] expData;
        logic err, expErr;
        int lat, acc;
        int sawValid;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 16'h0020;
        req_wdata = 32'h55 ^ {24'h0, refMem[32]} ^ 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sawValid = 0;
        for (int i = 0; i < LATENCY + 2; i++) begin
            if (rsp_valid === 1'b1) sawValid++;
            @(posedge clk); #1;
        end
        checks++; if (sawValid != 0) begin errors++; $display("[TB] FAIL dropped_store_rsp: valid seen %0d cycles want 0", sawValid); end
        modelAccess(1'b0, 2'd0, 32'h20, 0, expData, expErr);
        applyStimulus(1'b0, 2'd0, 16'h0020, '0, rdata, err, lat, acc);
        checks++; if (rdata !== expData) begin errors++; $display("[TB] FAIL dropped_store_data: got %h want %h", rdata, expData); end
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 16'h0010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < TIMEOUT) begin @(posedge clk); #1; lat++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_resp: valid=%b rdata=%h ready=%b want 0/0/1", rsp_valid, rsp_rdata, req_ready);
        end
    endtask

    // Back-to-back requests are accepted LATENCY+2 cycles apart
    task automatic test_back_to_back();
        logic [DW-1:0] rdata;
        logic err;
        int lat, acc0, acc1;
        applyStimulus(1'b0, 2'd0, 16'h0001, '0, rdata, err, lat, acc0);
        applyStimulus(1'b0, 2'd0, 16'h0002, '0, rdata, err, lat, acc1);
        checks++;
        if (acc1 - acc0 != LATENCY + 2) begin
            errors++;
            $display("[TB] FAIL throughput: accept spacing %0d want %0d", acc1 - acc0, LATENCY + 2);
        end
    endtask

    // Random mix of sizes, directions and addresses against the reference model
    task automatic test_random();
        logic [DW-1:0] rdata;
        logic [31:0] expData;
        logic err, expErr;
        int lat, acc, r, addr;
        logic [1:0] size;
        logic we;
        logic [31:0] wdata;
        for (int i = 0; i < 150; i++) begin
            we    = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 7);
            size  = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
            addr  = ($urandom_range(0, 15) == 0) ? $urandom_range(256, 511) : $urandom_range(0, 255);
            wdata = $urandom;
            modelAccess(we, size, addr, wdata, expData, expErr);
            applyStimulus(we, size, AW'(addr), wdata, rdata, err, lat, acc);
            checks++;
            if (rdata !== expData || err !== expErr || lat != LATENCY) begin
                errors++;
                $display("[TB] FAIL random #%0d we=%b size=%0d addr=%0h: rdata=%h err=%b lat=%0d want %h/%b/%0d",
                         i, we, size, addr, rdata, err, lat, expData, expErr, LATENCY);
            end
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        test_reset();
        test_fill();
        test_big_endian();
        test_hold();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
